// File: rtl/medi_time_src_if.sv
// Button inputs and display/time outputs of the medi_time_src time source.
// master = button/observer side, slave = the time source itself.
interface medi_time_src_if;
    logic       b_run;
    logic       b_inc;
    logic       b_clr;
    logic       b_step;
    logic [6:0] nums;
    logic [6:0] numb;
    logic [5:0] val;
    logic       tick;
    logic       running;

    modport master (
        output b_run, b_inc, b_clr, b_step,
        input  nums, numb, val, tick, running
    );

    modport slave (
        input  b_run, b_inc, b_clr, b_step,
        output nums, numb, val, tick, running
    );
endinterface

// File: rtl/medi_time_src.sv
// 0..60 time source with run/pause, increment, clear and seven-segment outputs.
// Optional macro MEDI_MANUAL_STEP_EN enables the b_step manual-advance button.
module medi_time_src #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input logic                clkin,
    input logic                rst_n,
    medi_time_src_if.slave     bus
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned VW = 6;
    localparam logic [VW-1:0] VAL_MAX  = VW'(60);
    localparam logic [PW-1:0] PSC_LAST = PW'(TICK_DIV - 1);

`ifdef MEDI_MANUAL_STEP_EN
    localparam int unsigned NB = 4;
`else
    localparam int unsigned NB = 3;
`endif

    localparam int unsigned B_INC  = 0;
    localparam int unsigned B_RUN  = 1;
    localparam int unsigned B_CLR  = 2;

    typedef enum logic {S_PAUSE = 1'b0, S_RUN = 1'b1} state_e;

    state_e        state_q;
    logic [VW-1:0] val_q;
    logic [PW-1:0] psc_q;
    logic          tick_q;

    logic [NB-1:0] btn_c;
    logic [NB-1:0] sync1_q, sync2_q, prev_q;
    logic [NB-1:0] edge_c;
    logic [1:0]    warm_q;
    logic          armed_c;

`ifdef MEDI_MANUAL_STEP_EN
    assign btn_c = {bus.b_step, bus.b_clr, bus.b_run, bus.b_inc};
`else
    logic unused_step_c;
    assign unused_step_c = bus.b_step;
    assign btn_c = {bus.b_clr, bus.b_run, bus.b_inc};
`endif

    // Edges are masked until the synchronizer holds real pin samples, so a
    // button held through reset release does not look like a fresh press.
    assign armed_c = (warm_q == 2'd3);
    assign edge_c  = sync2_q & ~prev_q & {NB{armed_c}};

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            warm_q  <= '0;
        end else begin
            sync1_q <= btn_c;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (!armed_c) warm_q <= warm_q + 2'd1;
        end
    end

    logic          clr_c, run_c, adv_c;
    logic [VW-1:0] val_next_c;

    assign clr_c = edge_c[B_CLR];
    assign run_c = edge_c[B_RUN];
`ifdef MEDI_MANUAL_STEP_EN
    assign adv_c = (edge_c[B_INC] && (state_q == S_PAUSE)) || edge_c[3];
`else
    assign adv_c = edge_c[B_INC] && (state_q == S_PAUSE);
`endif
    assign val_next_c = (val_q == VAL_MAX) ? '0 : val_q + VW'(1);

    // Priority: clear > run toggle > inc/step > prescaler advance.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_PAUSE;
            val_q   <= '0;
            psc_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (clr_c) begin
                state_q <= S_PAUSE;
                val_q   <= '0;
                psc_q   <= '0;
                tick_q  <= (val_q != '0);
            end else if (run_c) begin
                state_q <= (state_q == S_RUN) ? S_PAUSE : S_RUN;
                psc_q   <= '0;
            end else if (adv_c) begin
                val_q  <= val_next_c;
                tick_q <= 1'b1;
            end else if (state_q == S_RUN) begin
                if (psc_q == PSC_LAST) begin
                    psc_q  <= '0;
                    val_q  <= val_next_c;
                    tick_q <= 1'b1;
                end else begin
                    psc_q <= psc_q + PW'(1);
                end
            end
        end
    end

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1111011;
            default: seg = 7'b0000000;
        endcase
    endfunction

    assign bus.nums    = seg(4'(val_q / VW'(10)));
    assign bus.numb    = seg(4'(val_q % VW'(10)));
    assign bus.val     = val_q;
    assign bus.tick    = tick_q;
    assign bus.running = (state_q == S_RUN);

endmodule

// File: tb/tb_medi_time_src.sv
// Directed bench for medi_time_src with TICK_DIV=4 and hand-computed expectations.
module tb_medi_time_src;

    localparam int unsigned B_INC  = 0;
    localparam int unsigned B_RUN  = 1;
    localparam int unsigned B_CLR  = 2;
    localparam int unsigned B_STEP = 3;

    localparam logic [31:0] SEG0 = 32'h7E;
    localparam logic [31:0] SEG1 = 32'h30;
    localparam logic [31:0] SEG3 = 32'h79;
    localparam logic [31:0] SEG4 = 32'h33;
    localparam logic [31:0] SEG5 = 32'h5B;
    localparam logic [31:0] SEG6 = 32'h5F;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn;
    int         n_total;
    int         n_pass;

    medi_time_src_if bif ();

    assign bif.b_inc  = btn[B_INC];
    assign bif.b_run  = btn[B_RUN];
    assign bif.b_clr  = btn[B_CLR];
    assign bif.b_step = btn[B_STEP];

    medi_time_src #(.TICK_DIV(4)) dut (
        .clkin (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Pin high across exactly one rising edge; returns at the following falling edge.
    task automatic pulse(input int unsigned b);
        btn[b] = 1'b1;
        @(negedge clk);
        btn[b] = 1'b0;
    endtask

    task automatic inc_n(input int n);
        for (int i = 0; i < n; i++) begin
            pulse(B_INC);
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        btn     = 4'b0;
        rst_n   = 1'b0;

        #1;
        chk("rst_hold_val",  32'(bif.val),     32'd0);
        chk("rst_hold_nums", 32'(bif.nums),    SEG0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_nums",    32'(bif.nums),    SEG0);
        chk("rst_numb",    32'(bif.numb),    SEG0);
        chk("rst_val",     32'(bif.val),     32'd0);
        chk("rst_running", 32'(bif.running), 32'd0);
        chk("rst_tick",    32'(bif.tick),    32'd0);
        repeat (4) @(negedge clk);

        // Start running: acts on the 3rd edge, then one step per 4 cycles.
        pulse(B_RUN);
        @(negedge clk);
        chk("run_edge2_running", 32'(bif.running), 32'd0);
        @(negedge clk);
        chk("run_edge3_running", 32'(bif.running), 32'd1);
        chk("run_edge3_val",     32'(bif.val),     32'd0);
        repeat (3) @(negedge clk);
        chk("run_pre_step_val",  32'(bif.val),     32'd0);
        chk("run_pre_step_tick", 32'(bif.tick),    32'd0);
        @(negedge clk);
        chk("run_step1_val",     32'(bif.val),     32'd1);
        chk("run_step1_tick",    32'(bif.tick),    32'd1);
        @(negedge clk);
        chk("run_step1_tick_off", 32'(bif.tick),   32'd0);
        repeat (3) @(negedge clk);
        chk("run_step2_val",     32'(bif.val),     32'd2);
        chk("run_step2_tick",    32'(bif.tick),    32'd1);

        // Run up to 59, then 60 held one step, then wrap to 0.
        repeat (57 * 4) @(negedge clk);
        chk("run_val59",      32'(bif.val),     32'd59);
        chk("run_59_running", 32'(bif.running), 32'd1);
        repeat (4) @(negedge clk);
        chk("wrap_val60",  32'(bif.val),  32'd60);
        chk("wrap60_tick", 32'(bif.tick), 32'd1);
        chk("wrap60_nums", 32'(bif.nums), SEG6);
        chk("wrap60_numb", 32'(bif.numb), SEG0);
        repeat (3) @(negedge clk);
        chk("wrap60_held", 32'(bif.val),  32'd60);
        chk("wrap60_tick_off", 32'(bif.tick), 32'd0);
        @(negedge clk);
        chk("wrap_val0",  32'(bif.val),  32'd0);
        chk("wrap0_tick", 32'(bif.tick), 32'd1);
        chk("wrap0_nums", 32'(bif.nums), SEG0);
        chk("wrap0_numb", 32'(bif.numb), SEG0);

        // b_inc in RUN is ignored; prescaler keeps its normal pace.
        pulse(B_INC);
        repeat (2) @(negedge clk);
        chk("run_inc_ignored", 32'(bif.val), 32'd0);
        @(negedge clk);
        chk("run_inc_next_step", 32'(bif.val), 32'd1);

        // Pause mid-step: prescaler discarded, val kept.
        pulse(B_RUN);
        repeat (2) @(negedge clk);
        chk("pause_running", 32'(bif.running), 32'd0);
        chk("pause_val",     32'(bif.val),     32'd1);
        repeat (6) @(negedge clk);
        chk("pause_frozen",  32'(bif.val),     32'd1);

        // Increment while paused: 1 -> 9 -> 10.
        inc_n(8);
        chk("inc_val9", 32'(bif.val), 32'd9);
        pulse(B_INC);
        repeat (2) @(negedge clk);
        chk("inc_val10",  32'(bif.val),  32'd10);
        chk("inc10_nums", 32'(bif.nums), SEG1);
        chk("inc10_numb", 32'(bif.numb), SEG0);
        chk("inc10_tick", 32'(bif.tick), 32'd1);

        // Clear and inc rising together at 30: clear wins, one tick.
        inc_n(20);
        chk("inc_val30",  32'(bif.val),  32'd30);
        chk("inc30_nums", 32'(bif.nums), SEG3);
        btn[B_CLR] = 1'b1;
        btn[B_INC] = 1'b1;
        @(negedge clk);
        btn[B_CLR] = 1'b0;
        btn[B_INC] = 1'b0;
        repeat (2) @(negedge clk);
        chk("simul_val",     32'(bif.val),     32'd0);
        chk("simul_running", 32'(bif.running), 32'd0);
        chk("simul_tick",    32'(bif.tick),    32'd1);
        @(negedge clk);
        chk("simul_tick_off", 32'(bif.tick),   32'd0);
        chk("simul_val_after", 32'(bif.val),   32'd0);

        // Clear while already at 0 produces no tick.
        pulse(B_CLR);
        repeat (2) @(negedge clk);
        chk("clr0_val",  32'(bif.val),  32'd0);
        chk("clr0_tick", 32'(bif.tick), 32'd0);
        @(negedge clk);
        chk("clr0_tick_late", 32'(bif.tick), 32'd0);

        // Reach val=45 in RUN with prescaler=2, then reset asynchronously.
        inc_n(45);
        pulse(B_RUN);
        repeat (2) @(negedge clk);
        chk("pre_rst_running", 32'(bif.running), 32'd1);
        repeat (2) @(negedge clk);
        chk("pre_rst_val",  32'(bif.val),  32'd45);
        chk("pre_rst_nums", 32'(bif.nums), SEG4);
        chk("pre_rst_numb", 32'(bif.numb), SEG5);
        #2 rst_n = 1'b0;
        btn[B_RUN] = 1'b1;
        #1;
        chk("arst_val",     32'(bif.val),     32'd0);
        chk("arst_running", 32'(bif.running), 32'd0);
        chk("arst_tick",    32'(bif.tick),    32'd0);
        chk("arst_nums",    32'(bif.nums),    SEG0);
        chk("arst_numb",    32'(bif.numb),    SEG0);
        @(negedge clk);
        rst_n = 1'b1;
        // b_run stays held through release: must not register as a press.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_rst_tick", 32'(bif.tick), 32'd0);
        end
        chk("post_rst_val",     32'(bif.val),     32'd0);
        chk("held_btn_running", 32'(bif.running), 32'd0);
        btn[B_RUN] = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_release_running", 32'(bif.running), 32'd0);

        // Manual step button: advances only when the option is built in.
        pulse(B_STEP);
        repeat (2) @(negedge clk);
`ifdef MEDI_MANUAL_STEP_EN
        chk("step_val", 32'(bif.val), 32'd1);
`else
        chk("step_val", 32'(bif.val), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
